captouch_scan: RTL



---
 rtl/captouch_pkg.sv | 16 +
 rtl/captouch_debounce.sv | 35 +++
 rtl/captouch_scan.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/captouch_pkg.sv
// Shared types and sizing helpers for the multi-pad capacitive touch scanner.
package captouch_pkg;

    typedef enum logic [1:0] {DISCHARGE, CHARGE, EVAL} state_t;

    // Channel index width; a single pad still needs one bit.
    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Threshold arithmetic carries one extra bit so base + margin never wraps.
    function automatic int thr_w(input int cnt_w);
        return cnt_w + 1;
    endfunction

endpackage

// File: rtl/captouch_debounce.sv
// Per-pad touch debouncer: btn follows only after DEB_DEPTH equal consecutive samples.
module captouch_debounce #(
    parameter int DEB_DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic smp_vld,
    input  logic smp,
    output logic btn
);

    logic [DEB_DEPTH-1:0] hist;
    logic [DEB_DEPTH-1:0] hist_nxt;

    assign hist_nxt = {hist[DEB_DEPTH-2:0], smp};

    // btn is decided from the updated history so it moves on the same edge as the sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
            btn  <= 1'b0;
        end else if (clr) begin
            hist <= '0;
            btn  <= 1'b0;
        end else if (smp_vld) begin
            hist <= hist_nxt;
            if (&hist_nxt)
                btn <= 1'b1;
            else if (~|hist_nxt)
                btn <= 1'b0;
        end
    end

endmodule

// File: rtl/captouch_scan.sv
// Round-robin capacitive touch scanner: discharge, release, time the rise, compare to a per-pad baseline.
// Optional CAPTOUCH_BASELINE_TRACK_EN: untouched measurements nudge the baseline one step toward meas.
module captouch_scan
    import captouch_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int CNT_W         = 15,
    parameter int DISCHARGE_CYC = 10,
    parameter int TIMEOUT_CYC   = 30000,
    parameter int THRESH_SHIFT  = 3,
    parameter int DEB_DEPTH     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] cap_in,
    output logic [NUM_CH-1:0] cap_out,
    output logic [NUM_CH-1:0] cap_oe,
    output logic [NUM_CH-1:0] btn,
    input  logic              recal,
    output logic              calibrated,
    output logic [NUM_CH-1:0] timeout_err
);

    localparam int CH_W = ch_w(NUM_CH);
    localparam int TW   = thr_w(CNT_W);

    logic [NUM_CH-1:0]            sync1, sync2;
    state_t                       state;
    logic [CH_W-1:0]              ch;
    logic [CNT_W-1:0]             cnt, meas;
    logic                         to;
    logic [NUM_CH-1:0][CNT_W-1:0] base;
    logic [NUM_CH-1:0]            base_vld;
    logic [NUM_CH-1:0]            ch_mask;
    logic [TW-1:0]                thresh;
    logic                         sample;
    logic                         smp_vld;

    assign cap_out = '0;

    // Synchronisers survive recal so a pad already high is not re-metastabilised.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= cap_in;
            sync2 <= sync1;
        end
    end

    assign ch_mask = NUM_CH'(1) << ch;
    assign thresh  = {1'b0, base[ch]} + TW'(base[ch] >> THRESH_SHIFT);
    assign sample  = {1'b0, meas} > thresh;
    assign smp_vld = (state == EVAL) && !to && base_vld[ch];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= DISCHARGE;
            ch          <= '0;
            cnt         <= '0;
            meas        <= '0;
            to          <= 1'b0;
            cap_oe      <= '1;
            base        <= '0;
            base_vld    <= '0;
            calibrated  <= 1'b0;
            timeout_err <= '0;
        end else if (recal) begin
            state       <= DISCHARGE;
            ch          <= '0;
            cnt         <= '0;
            meas        <= '0;
            to          <= 1'b0;
            cap_oe      <= '1;
            base        <= '0;
            base_vld    <= '0;
            calibrated  <= 1'b0;
            timeout_err <= '0;
        end else begin
            case (state)
                DISCHARGE: begin
                    if (cnt == CNT_W'(DISCHARGE_CYC - 1)) begin
                        state  <= CHARGE;
                        cnt    <= '0;
                        cap_oe <= ~ch_mask;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CHARGE: begin
                    if (sync2[ch]) begin
                        state  <= EVAL;
                        meas   <= cnt;
                        to     <= 1'b0;
                        cap_oe <= '1;
                    end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state  <= EVAL;
                        meas   <= cnt;
                        to     <= 1'b1;
                        cap_oe <= '1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                EVAL: begin
                    if (to) begin
                        timeout_err[ch] <= 1'b1;
                    end else if (!base_vld[ch]) begin
                        base[ch]     <= meas;
                        base_vld[ch] <= 1'b1;
                        calibrated   <= &(base_vld | ch_mask);
                    end
`ifdef CAPTOUCH_BASELINE_TRACK_EN
                    else if (!sample) begin
                        // meas > base implies base < max and vice versa, so the step never wraps.
                        if (meas > base[ch])
                            base[ch] <= base[ch] + 1'b1;
                        else if (meas < base[ch])
                            base[ch] <= base[ch] - 1'b1;
                    end
`endif
                    ch    <= (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + 1'b1;
                    state <= DISCHARGE;
                    cnt   <= '0;
                end
                default: state <= DISCHARGE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_deb
        captouch_debounce #(.DEB_DEPTH(DEB_DEPTH)) u_deb (
            .clk     (clk),
            .reset   (reset),
            .clr     (recal),
            .smp_vld (smp_vld && (ch == CH_W'(i))),
            .smp     (sample),
            .btn     (btn[i])
        );
    end

endmodule
